// File: rtl/mem_hash_pkg.sv
// Shared constants for the mem_hash job scheduler: job framing and default sizing.
package mem_hash_pkg;
  localparam int unsigned BEATS_PER_JOB = 32;
  localparam int unsigned BEAT_W        = $clog2(BEATS_PER_JOB);
  localparam logic [BEAT_W-1:0] INIT_ADDR = BEAT_W'(BEATS_PER_JOB - 1);
  localparam int unsigned DEF_N         = 32;
  localparam int unsigned DEF_M         = 16;
  localparam int unsigned DEF_ID_WIDTH  = 32;
endpackage

// File: rtl/mem_hash_result_fifo.sv
// First-word fall-through synchronous FIFO holding {hash, index} result entries.
module mem_hash_result_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so push on full is allowed then.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/mem_hash_sched.sv
// Splits an upstream beat stream into 32-beat mem_hash jobs, credit-limits jobs to the lane
// count and queues the returned hash results for a valid/ready consumer.
module mem_hash_sched
  import mem_hash_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned M        = DEF_M,
  parameter int unsigned ID_WIDTH = DEF_ID_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N*32-1:0]     s_data,
  input  logic [ID_WIDTH-1:0] s_id,
  input  logic                s_last,
  output logic                hash_in_valid,
  output logic [4:0]          hash_in_addr,
  output logic [ID_WIDTH-1:0] hash_in_index,
  output logic [N*32-1:0]     hash_mem_in,
  input  logic                hash_out_ready,
  output logic                hash_in_ready,
  input  logic                hash_out_valid,
  input  logic [N*32-1:0]     hash_out_hash,
  input  logic [ID_WIDTH-1:0] hash_out_index,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N*32-1:0]     m_hash,
  output logic [ID_WIDTH-1:0] m_index,
  output logic [4:0]          outstanding,
  output logic                err_framing,
  output logic                err_overflow
);
  localparam logic [4:0] M_CNT = 5'(M);

  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [4:0]          out_q, out_d;
  logic                err_fr_q, err_fr_d, err_ov_q, err_ov_d, in_ready_q;
  logic                gate, accept, first, pop, overflow, fifo_full, fifo_empty;

  // Credit is only checked at a job boundary; a started job always runs to completion.
  assign gate          = (beat_q != '0) | (out_q < M_CNT);
  assign s_ready       = hash_out_ready & gate & rst_n;
  assign hash_in_valid = s_valid & gate & rst_n;
  assign accept        = s_valid & s_ready;
  assign first         = accept & (beat_q == '0);
  assign pop           = m_valid & m_ready;
  assign overflow      = hash_out_valid & fifo_full & ~pop;

  assign hash_in_addr  = beat_q;
  assign hash_in_index = (beat_q == '0) ? s_id : id_q;
  assign hash_mem_in   = s_data;
  assign hash_in_ready = in_ready_q;
  assign outstanding   = out_q;
  assign err_framing   = err_fr_q;
  assign err_overflow  = err_ov_q;
  assign m_valid       = ~fifo_empty;

  always_comb begin
    beat_d   = beat_q;
    id_d     = id_q;
    out_d    = out_q;
    err_fr_d = err_fr_q;
    err_ov_d = err_ov_q | overflow;
    if (accept) begin
      beat_d = beat_q + 1'b1;
      if (s_last != (beat_q == INIT_ADDR)) err_fr_d = 1'b1;
    end
    if (first) id_d = s_id;
    // Credit is returned on pop, never below zero.
    case ({first, pop & (out_q != '0)})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q     <= '0;
      id_q       <= '0;
      out_q      <= '0;
      err_fr_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      id_q       <= id_d;
      out_q      <= out_d;
      err_fr_q   <= err_fr_d;
      err_ov_q   <= err_ov_d;
      in_ready_q <= 1'b1;
    end
  end

  mem_hash_result_fifo #(
    .DEPTH (M),
    .WIDTH (N*32 + ID_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hash_out_valid),
    .wdata_i ({hash_out_hash, hash_out_index}),
    .pop_i   (pop),
    .rdata_o ({m_hash, m_index}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule
